// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants, state encoding and helpers for array_loader_16x8
//
// Purpose : one-hot state encoding, array geometry and small helpers used by
//           the loader top level and its register file.
// Contents: FILL/START/WAIT one-hot localparams, loader_state_e enum,
//           LOADER_WIDTH, LOADER_DEPTH, LOADER_PTR_W, LOADER_ADDR_W,
//           is_last_slot() helper.
package loader_pkg;

    // One-hot state codes, bit order {Qw, Qs, Qf}.
    localparam logic [2:0] FILL  = 3'b001;
    localparam logic [2:0] START = 3'b010;
    localparam logic [2:0] WAIT  = 3'b100;

    localparam int LOADER_WIDTH  = 8;
    localparam int LOADER_DEPTH  = 16;

    // The write pointer needs one extra bit so it can reach 16 once full.
    localparam int LOADER_PTR_W  = 5;
    localparam int LOADER_ADDR_W = 4;

    typedef enum logic [2:0] {
        ST_FILL  = FILL,
        ST_START = START,
        ST_WAIT  = WAIT
    } loader_state_e;

    // True when the pointer addresses the final slot of the array, i.e. the
    // next accepted word completes the batch.
    function automatic logic is_last_slot(input logic [LOADER_PTR_W-1:0] ptr);
        return ptr == LOADER_PTR_W'(LOADER_DEPTH - 1);
    endfunction

endpackage

// File: rtl/regfile_16x8.sv
// rtl/regfile_16x8.sv - 16-entry register array, one sync write port, one async read port
//
// Purpose : element storage for the loader. Contents are deliberately not
//           reset so that a reset mid-batch leaves previously written data
//           in place.
// Ports   : clk    - rising-edge clock
//           we     - write enable
//           waddr  - write address (4 bits)
//           wdata  - write data (WIDTH bits)
//           raddr  - read address (4 bits)
//           rdata  - combinational read data, mem[raddr]
module regfile_16x8
    import loader_pkg::*;
#(
    parameter int WIDTH = LOADER_WIDTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [LOADER_ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [LOADER_ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [0:LOADER_DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-cycle read so the finder can register mem[I] directly.
    assign rdata = mem[raddr];

endmodule

// File: rtl/array_loader_16x8.sv
// rtl/array_loader_16x8.sv - stream-to-array loader feeding the min/max finder
//
// Purpose : accepts 16 WIDTH-bit words over a valid/ready handshake, stores
//           them in a register array, pulses Start for one cycle, then holds
//           the array frozen until the finder returns Done.
// Ports   : Clk        - rising-edge clock
//           Resetb     - asynchronous active-low reset
//           Din        - incoming element
//           Din_valid  - Din is valid this cycle
//           Din_ready  - loader accepts Din this cycle (state decode only)
//           Done       - finder done pulse
//           Start      - one-cycle start pulse to the finder (state decode only)
//           Rd_addr    - finder read index
//           Rd_data    - combinational M[Rd_addr]
//           Count      - words written in the current batch, 0..16
//           Qf/Qs/Qw   - one-hot state bits for FILL/START/WAIT
//           Abort      - clears a partial batch while filling
//                        (present only when LOADER_ABORT_EN is defined)
// Macro   : LOADER_ABORT_EN enables the Abort input and its logic.
module array_loader_16x8
    import loader_pkg::*;
#(
    parameter int WIDTH = LOADER_WIDTH,
    parameter int DEPTH = LOADER_DEPTH
) (
    input  logic                     Clk,
    input  logic                     Resetb,
    input  logic [WIDTH-1:0]         Din,
    input  logic                     Din_valid,
    output logic                     Din_ready,
    input  logic                     Done,
    output logic                     Start,
    input  logic [LOADER_ADDR_W-1:0] Rd_addr,
    output logic [WIDTH-1:0]         Rd_data,
    output logic [LOADER_PTR_W-1:0]  Count,
    output logic                     Qf,
    output logic                     Qs,
    output logic                     Qw
`ifdef LOADER_ABORT_EN
    ,
    input  logic                     Abort
`endif
);

    loader_state_e            state;
    logic [2:0]               state_bits;
    logic [LOADER_PTR_W-1:0]  wptr;
    logic                     wr_en;

    // The 4-bit address space only covers a 16-entry array; the DEPTH
    // parameter exists for documentation and must stay at 16.
    localparam int DEPTH_CHECK = (DEPTH == LOADER_DEPTH) ? 1 : 0;
    logic depth_ok;
    assign depth_ok = (DEPTH_CHECK == 1);

    // A write happens only on a real handshake in FILL. An abort in the same
    // cycle wins over the handshake so the word never lands in the array.
`ifdef LOADER_ABORT_EN
    assign wr_en = (state == ST_FILL) && Din_valid && !Abort && depth_ok;
`else
    assign wr_en = (state == ST_FILL) && Din_valid && depth_ok;
`endif

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            state <= ST_FILL;
            wptr  <= '0;
        end else begin
            case (state)
                ST_FILL: begin
`ifdef LOADER_ABORT_EN
                    if (Abort) begin
                        wptr <= '0;
                    end else
`endif
                    if (wr_en) begin
                        wptr <= wptr + LOADER_PTR_W'(1);
                        if (is_last_slot(wptr)) begin
                            state <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Any word offered alongside Done is left for the
                    // producer to hold; it is taken in FILL next cycle.
                    if (Done) begin
                        state <= ST_FILL;
                        wptr  <= '0;
                    end
                end
                default: begin
                    state <= ST_FILL;
                    wptr  <= '0;
                end
            endcase
        end
    end

    // Outputs decode the state register only, so no input reaches them
    // combinationally.
    assign state_bits = state;
    assign Qf         = state_bits[0];
    assign Qs         = state_bits[1];
    assign Qw         = state_bits[2];
    assign Din_ready  = Qf;
    assign Start      = Qs;
    assign Count      = wptr;

    regfile_16x8 #(
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk   (Clk),
        .we    (wr_en),
        .waddr (wptr[LOADER_ADDR_W-1:0]),
        .wdata (Din),
        .raddr (Rd_addr),
        .rdata (Rd_data)
    );

endmodule
